// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant of selectable polarity.
// Define ARB_TIMEOUT_EN to add the watchdog that revokes long grants and pulses tmo.
module decoder_rr_arbiter #(
  parameter int   IN_WIDTH = 5,
  parameter logic ACTIVE   = 1'b1,
  parameter int   TIMEOUT  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [(1<<IN_WIDTH)-1:0]  req,
  output logic [(1<<IN_WIDTH)-1:0]  gnt,
  output logic                      gnt_valid,
  output logic [IN_WIDTH-1:0]       gnt_idx
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                      tmo
`endif
);

  localparam int N = 1 << IN_WIDTH;
  localparam logic [N-1:0] IDLE_GNT = {N{~ACTIVE}};

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("decoder_rr_arbiter: TIMEOUT must be at least 2");
  end

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t              r_state;
  logic [IN_WIDTH-1:0] r_ptr;
  logic [IN_WIDTH-1:0] r_idx;
  logic                r_valid;
  logic [N-1:0]        r_gnt;

  logic [IN_WIDTH-1:0] w_sel;
  logic [IN_WIDTH-1:0] w_cand;
  logic                w_any;
  logic                w_hold;
  logic                w_expire;

  function automatic logic [N-1:0] f_decode(input logic [IN_WIDTH-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return ACTIVE ? v : ~v;
  endfunction

  // Scan from the highest offset down so the nearest requester after ptr wins.
  always_comb begin
    w_sel  = r_ptr;
    w_any  = 1'b0;
    w_cand = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_cand = r_ptr + i[IN_WIDTH-1:0];
      if (req[w_cand]) begin
        w_sel = w_cand;
        w_any = 1'b1;
      end
    end
  end

  assign w_hold = req[r_idx];

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tmo;

  assign w_expire = w_hold && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign tmo      = r_tmo;
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_gnt   <= IDLE_GNT;
`ifdef ARB_TIMEOUT_EN
      r_cnt   <= '0;
      r_tmo   <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      r_tmo <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_GRANT;
            r_idx   <= w_sel;
            r_valid <= 1'b1;
            r_gnt   <= f_decode(w_sel);
`ifdef ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        S_GRANT: begin
          // A watchdog revoke is indistinguishable from a voluntary release.
          if (!w_hold || w_expire) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_gnt   <= IDLE_GNT;
            r_ptr   <= r_idx + 1'b1;
`ifdef ARB_TIMEOUT_EN
            r_tmo   <= w_expire;
`endif
          end else begin
`ifdef ARB_TIMEOUT_EN
            r_cnt   <= r_cnt + 1'b1;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_valid;
  assign gnt_idx   = r_idx;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Bench for decoder_rr_arbiter: active-high and active-low instances share stimulus,
// directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_decoder_rr_arbiter;

  localparam int IW = 3;
  localparam int N  = 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt_hi, gnt_lo;
  logic          valid_hi, valid_lo;
  logic [IW-1:0] idx_hi, idx_lo;
`ifdef ARB_TIMEOUT_EN
  logic          tmo_hi, tmo_lo;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  bit m_busy;
  bit m_tmo;
  int m_idx;
  int m_ptr;
  int m_held;

  decoder_rr_arbiter #(.IN_WIDTH(IW), .ACTIVE(1'b1), .TIMEOUT(TO)) u_dut_hi (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_hi), .gnt_valid(valid_hi), .gnt_idx(idx_hi)
`ifdef ARB_TIMEOUT_EN
    , .tmo(tmo_hi)
`endif
  );

  decoder_rr_arbiter #(.IN_WIDTH(IW), .ACTIVE(1'b0), .TIMEOUT(TO)) u_dut_lo (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_lo), .gnt_valid(valid_lo), .gnt_idx(idx_lo)
`ifdef ARB_TIMEOUT_EN
    , .tmo(tmo_lo)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_busy = 1'b0;
    m_tmo  = 1'b0;
    m_idx  = 0;
    m_ptr  = 0;
    m_held = 0;
  endtask

  // One clock edge of the arbiter as described in words: pick the first requester
  // at or after ptr; hold while the grantee requests; hand over ptr to grantee+1.
  task automatic model_step();
    m_tmo = 1'b0;
    if (!m_busy) begin
      if (req != '0) begin
        for (int k = 0; k < N; k++) begin
          if (req[(m_ptr + k) % N]) begin
            m_idx = (m_ptr + k) % N;
            break;
          end
        end
        m_busy = 1'b1;
        m_held = 1;
      end
    end else if (!req[m_idx]) begin
      m_busy = 1'b0;
      m_ptr  = (m_idx + 1) % N;
    end
`ifdef ARB_TIMEOUT_EN
    else if (m_held == TO) begin
      m_busy = 1'b0;
      m_ptr  = (m_idx + 1) % N;
      m_tmo  = 1'b1;
    end
`endif
    else begin
      m_held++;
    end
  endtask

  function automatic logic [N-1:0] exp_gnt();
    return m_busy ? (8'h01 << m_idx) : 8'h00;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({gnt_hi, valid_hi, idx_hi} !== {8'h00, 1'b0, 3'd0}) begin
      n_bad++;
      $display("FAIL reset_hi: gnt=%h valid=%b idx=%0d, want 00/0/0", gnt_hi, valid_hi, idx_hi);
    end
    n_cmp++;
    if ({gnt_lo, valid_lo, idx_lo} !== {8'hFF, 1'b0, 3'd0}) begin
      n_bad++;
      $display("FAIL reset_lo: gnt=%h valid=%b idx=%0d, want ff/0/0", gnt_lo, valid_lo, idx_lo);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    req = 8'h08;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({gnt_hi, valid_hi, idx_hi} !== {8'h08, 1'b1, 3'd3}) begin
        n_bad++;
        $display("FAIL single_hold[%0d]: gnt=%h valid=%b idx=%0d, want 08/1/3", c, gnt_hi, valid_hi, idx_hi);
      end
    end
    req = 8'h00;
    tick();
    n_cmp++;
    if ({gnt_hi, valid_hi, idx_hi} !== {8'h00, 1'b0, 3'd3}) begin
      n_bad++;
      $display("FAIL single_release: gnt=%h valid=%b idx=%0d, want 00/0/3", gnt_hi, valid_hi, idx_hi);
    end
    req = 8'h18;
    tick();
    n_cmp++;
    if ({gnt_hi, idx_hi} !== {8'h10, 3'd4}) begin
      n_bad++;
      $display("FAIL single_ptr: gnt=%h idx=%0d, want 10/4", gnt_hi, idx_hi);
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    req = 8'h20;
    tick();
    n_cmp++;
    if (gnt_hi !== 8'h20) begin
      n_bad++;
      $display("FAIL midrst_pre: gnt=%h, want 20", gnt_hi);
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if ({gnt_hi, valid_hi, idx_hi, gnt_lo} !== {8'h00, 1'b0, 3'd0, 8'hFF}) begin
      n_bad++;
      $display("FAIL midrst_async: gnt=%h valid=%b idx=%0d gnt_lo=%h, want 00/0/0/ff",
               gnt_hi, valid_hi, idx_hi, gnt_lo);
    end
    @(negedge clk);
    rst = 1'b0;
    req = 8'h00;
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 2, 7, 0, 2};
    for (int g = 0; g < 5; g++) begin
      req = 8'h85;
      tick();
      n_cmp++;
      if ({gnt_hi, valid_hi, idx_hi} !== {8'h01 << order[g], 1'b1, 3'(order[g])}) begin
        n_bad++;
        $display("FAIL rr_grant[%0d]: gnt=%h idx=%0d, want idx %0d", g, gnt_hi, idx_hi, order[g]);
      end
      req = 8'h85 & ~(8'h01 << order[g]);
      tick();
      n_cmp++;
      if ({gnt_hi, valid_hi} !== {8'h00, 1'b0}) begin
        n_bad++;
        $display("FAIL rr_idle[%0d]: gnt=%h valid=%b, want 00/0", g, gnt_hi, valid_hi);
      end
    end
    req = 8'h00;
  endtask

  task automatic test_wrap();
    req = 8'h40;
    tick();
    req = 8'h00;
    tick();
    req = 8'h81;
    tick();
    n_cmp++;
    if ({gnt_hi, idx_hi} !== {8'h80, 3'd7}) begin
      n_bad++;
      $display("FAIL wrap_to7: gnt=%h idx=%0d, want 80/7", gnt_hi, idx_hi);
    end
    req = 8'h01;
    tick();
    req = 8'h81;
    tick();
    n_cmp++;
    if ({gnt_hi, idx_hi} !== {8'h01, 3'd0}) begin
      n_bad++;
      $display("FAIL wrap_to0: gnt=%h idx=%0d, want 01/0", gnt_hi, idx_hi);
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_polarity();
    req = 8'h02;
    tick();
    n_cmp++;
    if ({gnt_lo, valid_lo, idx_lo} !== {8'hFD, 1'b1, 3'd1}) begin
      n_bad++;
      $display("FAIL pol_grant: gnt_lo=%h valid=%b idx=%0d, want fd/1/1", gnt_lo, valid_lo, idx_lo);
    end
    req = 8'h00;
    tick();
    n_cmp++;
    if ({gnt_lo, valid_lo} !== {8'hFF, 1'b0}) begin
      n_bad++;
      $display("FAIL pol_idle: gnt_lo=%h valid=%b, want ff/0", gnt_lo, valid_lo);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    req = 8'h03;
    for (int rep = 0; rep < 2; rep++) begin
      for (int c = 0; c < TO; c++) begin
        tick();
        n_cmp++;
        if ({gnt_hi, valid_hi, tmo_hi} !== {8'h01 << rep, 1'b1, 1'b0}) begin
          n_bad++;
          $display("FAIL tmo_hold[%0d.%0d]: gnt=%h valid=%b tmo=%b, want %h/1/0",
                   rep, c, gnt_hi, valid_hi, tmo_hi, 8'h01 << rep);
        end
      end
      tick();
      n_cmp++;
      if ({gnt_hi, valid_hi, tmo_hi, tmo_lo} !== {8'h00, 1'b0, 1'b1, 1'b1}) begin
        n_bad++;
        $display("FAIL tmo_pulse[%0d]: gnt=%h valid=%b tmo=%b/%b, want 00/0/1/1",
                 rep, gnt_hi, valid_hi, tmo_hi, tmo_lo);
      end
    end
    tick();
    n_cmp++;
    if ({gnt_hi, tmo_hi} !== {8'h01, 1'b0}) begin
      n_bad++;
      $display("FAIL tmo_regrant: gnt=%h tmo=%b, want 01/0", gnt_hi, tmo_hi);
    end
    req = 8'h00;
    tick();
    n_cmp++;
    if ({valid_hi, tmo_hi} !== {1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL tmo_normal_release: valid=%b tmo=%b, want 0/0", valid_hi, tmo_hi);
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        req = ($urandom_range(0, 1) == 0) ? 8'($urandom) : (8'($urandom) & 8'($urandom));
      end
      tick();
      n_cmp++;
      if ({gnt_hi, valid_hi, idx_hi} !== {exp_gnt(), m_busy, 3'(m_idx)}) begin
        n_bad++;
        $display("FAIL rand_hi[%0d]: req=%h gnt=%h valid=%b idx=%0d, want %h/%b/%0d",
                 c, req, gnt_hi, valid_hi, idx_hi, exp_gnt(), m_busy, m_idx);
      end
      n_cmp++;
      if ({gnt_lo, valid_lo, idx_lo} !== {~exp_gnt(), m_busy, 3'(m_idx)}) begin
        n_bad++;
        $display("FAIL rand_lo[%0d]: req=%h gnt=%h valid=%b idx=%0d, want %h/%b/%0d",
                 c, req, gnt_lo, valid_lo, idx_lo, ~exp_gnt(), m_busy, m_idx);
      end
`ifdef ARB_TIMEOUT_EN
      n_cmp++;
      if ({tmo_hi, tmo_lo} !== {m_tmo, m_tmo}) begin
        n_bad++;
        $display("FAIL rand_tmo[%0d]: tmo=%b/%b, want %b", c, tmo_hi, tmo_lo, m_tmo);
      end
`endif
    end
    req = 8'h00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid_grant();
    test_round_robin();
    test_wrap();
    test_polarity();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
